// File: rtl/deserializer_feed.sv
// Serial-to-byte assembler feeding a downstream queue: collects 8 bits, waits
// for queue room, then presents the byte with a data_ready/ack_in handshake.
module deserializer_feed #(
  parameter int MSB_FIRST = 1
) (
  input  logic       clock_100KHZ,
  input  logic       reset,
  input  logic       data_in,
  input  logic       write_in,
  input  logic       ack_in,
  input  logic [3:0] queue_len_in,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       status_out,
  output logic [3:0] bit_count_out,
  output logic [1:0] o_state
);

  // Handshake: data_ready=1 means data_out is valid and is held stable; the
  // first cycle with ack_in=1 while waiting completes the transfer, and any
  // further ack_in cycles are ignored because the FSM has already left WAIT_ACK.
  typedef enum logic [1:0] {
    RECEIVE   = 2'd0,
    FULL_WAIT = 2'd1,
    SEND      = 2'd2,
    WAIT_ACK  = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_shift;
  logic [3:0] r_count;
  logic [7:0] r_data;
  logic       r_ready;

  state_t     w_next_state;
  logic [7:0] w_shift_next;
  logic [3:0] w_count_next;
  logic [7:0] w_data_next;
  logic       w_ready_next;
  logic [7:0] w_shifted;
  logic       w_queue_full;

  assign w_queue_full = (queue_len_in >= 4'd8);
  assign w_shifted    = (MSB_FIRST != 0) ? {r_shift[6:0], data_in}
                                         : {data_in, r_shift[7:1]};

  always_comb begin
    w_next_state = r_state;
    w_shift_next = r_shift;
    w_count_next = r_count;
    w_data_next  = r_data;
    w_ready_next = r_ready;
    case (r_state)
      RECEIVE: begin
        if (write_in && (r_count != 4'd8)) begin
          w_shift_next = w_shifted;
          w_count_next = r_count + 4'd1;
          if (r_count == 4'd7) begin
            w_next_state = w_queue_full ? FULL_WAIT : SEND;
          end
        end
      end
      FULL_WAIT: begin
        if (!w_queue_full) begin
          w_next_state = SEND;
        end
      end
      SEND: begin
        // Queue occupancy is no longer consulted here; the queue guards itself.
        w_data_next  = r_shift;
        w_ready_next = 1'b1;
        w_next_state = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_in) begin
          w_ready_next = 1'b0;
          w_count_next = 4'd0;
          w_shift_next = 8'd0;
          w_next_state = RECEIVE;
        end
      end
      default: begin
        w_next_state = RECEIVE;
      end
    endcase
  end

  always_ff @(posedge clock_100KHZ) begin
    if (!reset) begin
      r_state <= RECEIVE;
      r_shift <= 8'd0;
      r_count <= 4'd0;
      r_data  <= 8'd0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_shift <= w_shift_next;
      r_count <= w_count_next;
      r_data  <= w_data_next;
      r_ready <= w_ready_next;
    end
  end

  assign data_out      = r_data;
  assign data_ready    = r_ready;
  assign status_out    = (r_state != RECEIVE);
  assign bit_count_out = r_count;
  assign o_state       = r_state;

endmodule
